// File: rtl/hysteresis_switch_ctl_if.sv
// Host/switch-facing signal bundle for hysteresis_switch_ctl.
// Valid/ack rule: an event is held while event_valid is high and is consumed
// at the rising edge where event_ack is high; ack while not valid is ignored.
interface hysteresis_switch_ctl_if;
  logic        cfg_write;
  logic [1:0]  cfg_select;
  logic [15:0] cfg_data;
  logic        output_value;
  logic        event_ack;
  logic        clk_enable;
  logic [15:0] filter_level;
  logic [15:0] filter_period;
  logic        cfg_busy;
  logic        event_valid;
  logic        event_rising;
  logic        event_overflow;

  modport master (
    output cfg_write, cfg_select, cfg_data, output_value, event_ack,
    input  clk_enable, filter_level, filter_period, cfg_busy,
           event_valid, event_rising, event_overflow
  );

  modport slave (
    input  cfg_write, cfg_select, cfg_data, output_value, event_ack,
    output clk_enable, filter_level, filter_period, cfg_busy,
           event_valid, event_rising, event_overflow
  );
endinterface

// File: rtl/hysteresis_switch_ctl.sv
// Prescaler, safe-point config commit and edge-event reporter for one
// hysteresis_switch instance. All outputs come straight from registers.
module hysteresis_switch_ctl #(
  parameter logic [15:0] RESET_LEVEL  = 16'h0008,
  parameter logic [15:0] RESET_PERIOD = 16'h0010
) (
  input logic                    clk,
  input logic                    reset_n,
  hysteresis_switch_ctl_if.slave ctl_if
);

  localparam logic [1:0] SEL_LEVEL  = 2'd0;
  localparam logic [1:0] SEL_PERIOD = 2'd1;
  localparam logic [1:0] SEL_DIV    = 2'd2;
  localparam logic [1:0] SEL_CTRL   = 2'd3;

  logic [15:0] pending_level_q, pending_level_d;
  logic [15:0] pending_period_q, pending_period_d;
  logic [15:0] level_q, level_d;
  logic [15:0] period_q, period_d;
  logic [15:0] divider_q, divider_d;
  logic [15:0] count_q, count_d;
  logic        run_q, run_d;
  logic        commit_q, commit_d;
  logic        clk_en_q, clk_en_d;
  logic        prev_q, prev_d;
  logic        armed_q, armed_d;
  logic        valid_q, valid_d;
  logic        rising_q, rising_d;
  logic        ovf_q, ovf_d;

  logic ctrl_wr;
  logic commit_set;
  logic clear_ovf;
  logic apply;
  logic edge_seen;

  assign ctrl_wr    = ctl_if.cfg_write && (ctl_if.cfg_select == SEL_CTRL);
  assign commit_set = ctrl_wr && ctl_if.cfg_data[1];
  assign clear_ovf  = ctrl_wr && ctl_if.cfg_data[2];
  assign edge_seen  = armed_q && (ctl_if.output_value != prev_q);

  // Stopped: a commit (even one arriving this cycle) applies at once.
  // Running: only an already-pending commit applies, on a strobe cycle.
  assign apply = run_q ? (commit_q && clk_en_q) : (commit_q || commit_set);

  always_comb begin
    pending_level_d  = pending_level_q;
    pending_period_d = pending_period_q;
    divider_d        = divider_q;
    run_d            = run_q;
    if (ctl_if.cfg_write) begin
      case (ctl_if.cfg_select)
        SEL_LEVEL:  pending_level_d  = ctl_if.cfg_data;
        SEL_PERIOD: pending_period_d = ctl_if.cfg_data;
        SEL_DIV:    divider_d        = ctl_if.cfg_data;
        default:    run_d            = ctl_if.cfg_data[0];
      endcase
    end
  end

  always_comb begin
    count_d  = divider_q;
    clk_en_d = 1'b0;
    if (run_q) begin
      if (count_q == 16'd0) begin
        clk_en_d = 1'b1;
      end else begin
        count_d = count_q - 16'd1;
      end
    end
  end

  always_comb begin
    level_d  = level_q;
    period_d = period_q;
    commit_d = commit_q || commit_set;
    if (apply) begin
      level_d  = pending_level_q;
      period_d = pending_period_q;
      commit_d = 1'b0;
    end
  end

  always_comb begin
    prev_d   = ctl_if.output_value;
    armed_d  = 1'b1;
    valid_d  = valid_q;
    rising_d = rising_q;
    ovf_d    = ovf_q && !clear_ovf;
    if (edge_seen && (!valid_q || ctl_if.event_ack)) begin
      valid_d  = 1'b1;
      rising_d = ctl_if.output_value;
    end else if (edge_seen) begin
      ovf_d = 1'b1;
    end else if (ctl_if.event_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_level_q  <= RESET_LEVEL;
      pending_period_q <= RESET_PERIOD;
      level_q          <= RESET_LEVEL;
      period_q         <= RESET_PERIOD;
      divider_q        <= 16'd0;
      count_q          <= 16'd0;
      run_q            <= 1'b0;
      commit_q         <= 1'b0;
      clk_en_q         <= 1'b0;
      prev_q           <= 1'b0;
      armed_q          <= 1'b0;
      valid_q          <= 1'b0;
      rising_q         <= 1'b0;
      ovf_q            <= 1'b0;
    end else begin
      pending_level_q  <= pending_level_d;
      pending_period_q <= pending_period_d;
      level_q          <= level_d;
      period_q         <= period_d;
      divider_q        <= divider_d;
      count_q          <= count_d;
      run_q            <= run_d;
      commit_q         <= commit_d;
      clk_en_q         <= clk_en_d;
      prev_q           <= prev_d;
      armed_q          <= armed_d;
      valid_q          <= valid_d;
      rising_q         <= rising_d;
      ovf_q            <= ovf_d;
    end
  end

  assign ctl_if.clk_enable     = clk_en_q;
  assign ctl_if.filter_level   = level_q;
  assign ctl_if.filter_period  = period_q;
  assign ctl_if.cfg_busy       = commit_q;
  assign ctl_if.event_valid    = valid_q;
  assign ctl_if.event_rising   = rising_q;
  assign ctl_if.event_overflow = ovf_q;

endmodule
